// File: rtl/adder_byte_loader.sv
// -----------------------------------------------------------------------------
// adder_byte_loader
//
// Operand-loading stage that sits in front of a 32-bit combinational adder.
// Two 32-bit operands arrive as eight bytes over a narrow valid/ready port.
// They are assembled into registered A/B buses that drive the adder. After a
// programmable settle window the adder's 33-bit SUM is captured. The result
// is then offered on a valid/ready output.
//
// Byte order: bytes 0..3 fill A and bytes 4..7 fill B, each little-endian.
//
// Parameters
//   SETTLE_CYCLES : cycles from the 8th accepted byte to SUM capture (1..15).
//                   The adder is a SETTLE_CYCLES multicycle path.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous active-high reset
//   in_data    in   8   operand byte
//   in_valid   in   1   in_data valid
//   in_ready   out  1   byte accepted this cycle (only while loading)
//   out_a      out  32  registered operand A to adder
//   out_b      out  32  registered operand B to adder
//   sum_in     in   33  adder SUM return (carry in bit 32)
//   res_data   out  33  captured sum
//   res_valid  out  1   res_data valid
//   res_ready  in   1   consumer takes result
// -----------------------------------------------------------------------------
module adder_byte_loader #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    input  logic [32:0] sum_in,
    output logic [32:0] res_data,
    output logic        res_valid,
    input  logic        res_ready
);

    // Catch an out-of-range settle window at elaboration time rather than
    // letting the 4-bit counter silently wrap.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("adder_byte_loader: SETTLE_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Last value of the settle counter; capture happens on the edge where the
    // counter holds this value.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  byte_cnt_q;
    logic [3:0]  settle_cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [32:0] res_q;
    logic        res_valid_q;

    // Bit offset of the byte lane addressed by the low two count bits.
    logic [4:0]  lane_lsb;

    assign lane_lsb  = {byte_cnt_q[1:0], 3'b000};

    // in_ready is a pure decode of the state register, so it can never be
    // high in the same cycle as res_valid (which is only set in DONE).
    assign in_ready  = (state_q == LOAD);
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign res_data  = res_q;
    assign res_valid = res_valid_q;

    // NOTE: all state, including the wide operand and result registers, is
    // reset here because the outputs have defined reset values and a partial
    // load must leave no residue; every assignment is non-blocking so all
    // registers update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD;
            byte_cnt_q   <= 3'd0;
            settle_cnt_q <= 4'd0;
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            res_q        <= 33'd0;
            res_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid) begin
                        // Bit 2 of the count selects the operand; the low
                        // bits select the byte lane. Other lanes hold.
                        if (!byte_cnt_q[2]) begin
                            a_q[lane_lsb +: 8] <= in_data;
                        end else begin
                            b_q[lane_lsb +: 8] <= in_data;
                        end
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd7) begin
                            byte_cnt_q   <= 3'd0;
                            settle_cnt_q <= 4'd0;
                            state_q      <= SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    // Operands are frozen; the adder resolves across
                    // SETTLE_CYCLES full cycles before sum_in is sampled.
                    if (settle_cnt_q == SETTLE_LAST) begin
                        res_q        <= sum_in;
                        res_valid_q  <= 1'b1;
                        settle_cnt_q <= 4'd0;
                        state_q      <= DONE;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end

                DONE: begin
                    // res_valid is always high here, so res_ready alone
                    // completes the handshake.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= LOAD;
                    end
                end

                default: begin
                    state_q <= LOAD;
                end
            endcase
        end
    end

endmodule
